// File: rtl/arb_pkg.sv
// Shared FSM state type, constants and helpers for fifo_rr_drain_arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int PERF_CNT_W = 32;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_rr_drain_arbiter_rr_pick.sv
// Rotating priority encoder: first asserted req scanning ptr+1, ptr+2, ... modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic                any,
    output logic [ID_WIDTH-1:0] winner
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [ID_WIDTH-1:0] idx;
            idx = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin burst drain of NUM_REQ FIFO read ports onto one tagged output stream.
// Define ARB_PERF_CNT_EN to add per-requester read counters and a stall-cycle counter.
module fifo_rr_drain_arbiter
    import arb_pkg::*;
#(
    parameter int DATA_WIDTH = 65,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          Clk,
    input  logic                          Clear_in,
    input  logic                          stall,
    input  logic [NUM_REQ-1:0]            fifo_empty,
    output logic [NUM_REQ-1:0]            fifo_read_en,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] fifo_data,
    input  logic [NUM_REQ-1:0]            fifo_data_valid,
    output logic [DATA_WIDTH-1:0]         Data_out,
    output logic                          Data_valid,
    output logic [ID_WIDTH-1:0]           Src_id,
    output logic                          Busy
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [NUM_REQ*PERF_CNT_W-1:0] perf_beats,
    output logic [PERF_CNT_W-1:0]         perf_stall_cycles
`endif
);

    localparam int                BEAT_W    = clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    state_t                r_state;
    logic [ID_WIDTH-1:0]   r_grant;
    logic [ID_WIDTH-1:0]   r_ptr;
    logic [BEAT_W-1:0]     r_beat_cnt;
    logic                  r_pend_valid;
    logic [ID_WIDTH-1:0]   r_pend_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_data_valid;
    logic [ID_WIDTH-1:0]   r_src_id;

    logic [NUM_REQ-1:0]    w_req;
    logic                  w_any;
    logic [ID_WIDTH-1:0]   w_winner;
    logic                  w_read;
    logic [NUM_REQ-1:0]    w_read_en;

    assign w_req = ~fifo_empty;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_WIDTH(ID_WIDTH)
    ) u_rr_pick (
        .req   (w_req),
        .ptr   (r_ptr),
        .any   (w_any),
        .winner(w_winner)
    );

    // Clear_in gates the strobe directly so it drops the instant reset asserts.
    assign w_read = (r_state == BURST) && !stall && !fifo_empty[r_grant] && !Clear_in;

    always_comb begin
        w_read_en          = '0;
        w_read_en[r_grant] = w_read;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Clear_in) begin
        if (Clear_in) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_ptr      <= ID_WIDTH'(NUM_REQ - 1);
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!stall && w_any) begin
                        r_grant    <= w_winner;
                        r_beat_cnt <= '0;
                        r_state    <= BURST;
                    end
                end
                BURST: begin
                    if (w_read) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_state <= IDLE;
                            r_ptr   <= r_grant;
                        end
                    end else if (!stall && fifo_empty[r_grant]) begin
                        r_state <= IDLE;
                        r_ptr   <= r_grant;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Return path: the FIFO answers one cycle after the read, we register it once more.
    always_ff @(posedge Clk or posedge Clear_in) begin
        if (Clear_in) begin
            r_pend_valid <= 1'b0;
            r_pend_id    <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_src_id     <= '0;
        end else begin
            r_pend_valid <= w_read;
            r_pend_id    <= r_grant;
            if (r_pend_valid && fifo_data_valid[r_pend_id]) begin
                r_data       <= fifo_data[r_pend_id*DATA_WIDTH +: DATA_WIDTH];
                r_src_id     <= r_pend_id;
                r_data_valid <= 1'b1;
            end else begin
                r_data_valid <= 1'b0;
            end
        end
    end

    assign fifo_read_en = w_read_en;
    assign Data_out     = r_data;
    assign Data_valid   = r_data_valid;
    assign Src_id       = r_src_id;
    assign Busy         = (r_state == BURST);

`ifdef ARB_PERF_CNT_EN
    logic [NUM_REQ*PERF_CNT_W-1:0] r_perf_beats;
    logic [PERF_CNT_W-1:0]         r_perf_stall;

    always_ff @(posedge Clk or posedge Clear_in) begin
        if (Clear_in) begin
            r_perf_beats <= '0;
            r_perf_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_read_en[i] && (r_perf_beats[i*PERF_CNT_W +: PERF_CNT_W] != '1))
                    r_perf_beats[i*PERF_CNT_W +: PERF_CNT_W] <=
                        r_perf_beats[i*PERF_CNT_W +: PERF_CNT_W] + 1'b1;
            end
            if (stall && !(&fifo_empty) && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 1'b1;
        end
    end

    assign perf_beats        = r_perf_beats;
    assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// Directed self-checking bench for fifo_rr_drain_arbiter with behavioural FIFO read ports.
module tb_fifo_rr_drain_arbiter;

    localparam int DW  = 65;
    localparam int NR  = 4;
    localparam int MB  = 4;
    localparam int IDW = 2;

    logic              Clk = 1'b0;
    logic              Clear_in;
    logic              stall;
    logic [NR-1:0]     fifo_empty;
    logic [NR-1:0]     fifo_read_en;
    logic [NR*DW-1:0]  fifo_data;
    logic [NR-1:0]     fifo_data_valid;
    logic [DW-1:0]     Data_out;
    logic              Data_valid;
    logic [IDW-1:0]    Src_id;
    logic              Busy;
`ifdef ARB_PERF_CNT_EN
    logic [NR*32-1:0]  perf_beats;
    logic [31:0]       perf_stall_cycles;
`endif

    fifo_rr_drain_arbiter #(
        .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB), .ID_WIDTH(IDW)
    ) dut (
        .Clk            (Clk),
        .Clear_in       (Clear_in),
        .stall          (stall),
        .fifo_empty     (fifo_empty),
        .fifo_read_en   (fifo_read_en),
        .fifo_data      (fifo_data),
        .fifo_data_valid(fifo_data_valid),
        .Data_out       (Data_out),
        .Data_valid     (Data_valid),
        .Src_id         (Src_id),
        .Busy           (Busy)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_beats       (perf_beats),
        .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] w(input int src, input int seq);
        return {1'b1, 32'(src), 32'(seq)};
    endfunction

    // Behavioural FIFOs: registered data one cycle after ReadEn; sat_mode makes all of them bottomless.
    logic [DW-1:0] mem [NR][16];
    logic [DW-1:0] data_reg [NR];
    int            wr_ptr [NR];
    int            rd_ptr [NR];
    int            sat_seq [NR];
    logic          sat_mode = 1'b0;

    initial begin
        for (int i = 0; i < NR; i++) begin
            wr_ptr[i] = 0; rd_ptr[i] = 0; sat_seq[i] = 0; data_reg[i] = '0;
        end
        fifo_data_valid = '0;
    end

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            fifo_empty[i]         = sat_mode ? 1'b0 : (wr_ptr[i] == rd_ptr[i]);
            fifo_data[i*DW +: DW] = data_reg[i];
        end
    end

    always @(posedge Clk) begin
        for (int i = 0; i < NR; i++) begin
            if (fifo_read_en[i]) begin
                fifo_data_valid[i] <= 1'b1;
                if (sat_mode) begin
                    data_reg[i] <= w(i, sat_seq[i]);
                    sat_seq[i]  <= sat_seq[i] + 1;
                end else begin
                    data_reg[i] <= mem[i][rd_ptr[i] % 16];
                    rd_ptr[i]   <= rd_ptr[i] + 1;
                end
            end else begin
                fifo_data_valid[i] <= 1'b0;
            end
        end
    end

    task automatic push(input int f, input logic [DW-1:0] d);
        mem[f][wr_ptr[f] % 16] = d;
        wr_ptr[f]++;
    endtask

    // Output monitor plus per-cycle structural checks on the read strobes.
    typedef struct {
        logic [IDW-1:0] src;
        logic [DW-1:0]  data;
        int             cyc;
    } out_t;
    out_t out_q[$];

    always @(negedge Clk) begin
        check("read_en_onehot0", 128'($onehot0(fifo_read_en)), 128'(1));
        check("read_while_empty", 128'(fifo_read_en & fifo_empty), 128'(0));
        if (Data_valid) out_q.push_back('{src: Src_id, data: Data_out, cyc: cyc});
    end

    task automatic check_entry(input string tag, input int idx, input int src,
                               input logic [DW-1:0] data, input int c);
        if (idx < out_q.size()) begin
            check({tag, ".src"},  128'(out_q[idx].src),  128'(src));
            check({tag, ".data"}, 128'(out_q[idx].data), 128'(data));
            check({tag, ".cyc"},  128'(out_q[idx].cyc),  128'(c));
        end else begin
            check({tag, ".missing"}, 128'(out_q.size()), 128'(idx + 1));
        end
    endtask

    initial begin
        int base;
        int r3;
        int exp_src [8];
        int exp_seq [8];
        int exp_off [8];
        int cnt [NR];
        int mx, mn;

        Clear_in = 1'b1;
        stall    = 1'b0;

        // Reset state, then an asynchronous Clear_in pulse in the middle of a FIFO2 burst.
        push(2, w(2, 0)); push(2, w(2, 1)); push(2, w(2, 2));
        @(negedge Clk);
        check("rst.data_out",   128'(Data_out),     128'(0));
        check("rst.data_valid", 128'(Data_valid),   128'(0));
        check("rst.src_id",     128'(Src_id),       128'(0));
        check("rst.busy",       128'(Busy),         128'(0));
        check("rst.read_en",    128'(fifo_read_en), 128'(0));
        Clear_in = 1'b0;
        @(negedge Clk);
        check("rst.first_grant", 128'(fifo_read_en), 128'(4'b0100));
        @(negedge Clk);
        #2 Clear_in = 1'b1;
        #1 check("rst.async_read_en", 128'(fifo_read_en), 128'(0));
        check("rst.async_busy", 128'(Busy), 128'(0));
        @(negedge Clk);
        check("rst.discard", 128'(Data_valid), 128'(0));
        out_q.delete();
        Clear_in = 1'b0;
        base = cyc;
        @(negedge Clk);
        check("rst.regrant", 128'(fifo_read_en), 128'(4'b0100));
        repeat (7) @(negedge Clk);
        check("rst.count", 128'(out_q.size()), 128'(2));
        check_entry("rst.w1", 0, 2, w(2, 1), base + 3);
        check_entry("rst.w2", 1, 2, w(2, 2), base + 4);

        // Burst length and rotation: FIFO0 x6, FIFO1 x2.
        Clear_in = 1'b1;
        @(negedge Clk);
        for (int i = 0; i < 6; i++) push(0, w(0, i));
        for (int i = 0; i < 2; i++) push(1, w(1, i));
        out_q.delete();
        Clear_in = 1'b0;
        base = cyc;
        @(negedge Clk);
        check("burst.busy", 128'(Busy), 128'(1));
        repeat (14) @(negedge Clk);
        exp_src = '{0, 0, 0, 0, 1, 1, 0, 0};
        exp_seq = '{0, 1, 2, 3, 0, 1, 4, 5};
        exp_off = '{3, 4, 5, 6, 8, 9, 12, 13};
        check("burst.count", 128'(out_q.size()), 128'(8));
        for (int i = 0; i < 8; i++)
            check_entry($sformatf("burst.w%0d", i), i, exp_src[i],
                        w(exp_src[i], exp_seq[i]), base + exp_off[i]);
`ifdef ARB_PERF_CNT_EN
        check("perf.beats0", 128'(perf_beats[0 +: 32]),  128'(6));
        check("perf.beats1", 128'(perf_beats[32 +: 32]), 128'(2));
`endif

        // Stall one cycle after the read of 0xA5; beat count must resume, not restart.
        Clear_in = 1'b1;
        @(negedge Clk);
        push(0, 65'hA5);
        for (int i = 0; i < 4; i++) push(0, w(0, 16 + i));
        out_q.delete();
        Clear_in = 1'b0;
        base = cyc;
        @(negedge Clk);
        check("stall.read_a5", 128'(fifo_read_en), 128'(4'b0001));
        @(negedge Clk);
        stall = 1'b1;
        #1 check("stall.block0", 128'(fifo_read_en), 128'(0));
        @(negedge Clk);
        check("stall.a5_valid", 128'(Data_valid), 128'(1));
        check("stall.a5_data",  128'(Data_out),   128'(65'hA5));
        check("stall.block1",   128'(fifo_read_en), 128'(0));
        @(negedge Clk);
        check("stall.block2", 128'(fifo_read_en), 128'(0));
        check("stall.busy",   128'(Busy), 128'(1));
        @(negedge Clk);
        stall = 1'b0;
        repeat (8) @(negedge Clk);
        check("stall.count", 128'(out_q.size()), 128'(5));
        check_entry("stall.a5", 0, 0, 65'hA5, base + 3);
        check_entry("stall.b0", 1, 0, w(0, 16), base + 7);
        check_entry("stall.b1", 2, 0, w(0, 17), base + 8);
        check_entry("stall.b2", 3, 0, w(0, 18), base + 9);
        check_entry("stall.b3", 4, 0, w(0, 19), base + 11);
`ifdef ARB_PERF_CNT_EN
        check("perf.stall_cycles", 128'(perf_stall_cycles), 128'(3));
`endif

        // Early end: a single word in FIFO3 ends its burst after one read and moves ptr to 3.
        Clear_in = 1'b1;
        @(negedge Clk);
        push(3, w(3, 0));
        out_q.delete();
        r3 = rd_ptr[3];
        Clear_in = 1'b0;
        @(negedge Clk);
        check("early.grant3", 128'(fifo_read_en), 128'(4'b1000));
        @(negedge Clk);
        check("early.no_second", 128'(fifo_read_en), 128'(0));
        @(negedge Clk);
        check("early.idle",  128'(Busy), 128'(0));
        check("early.reads", 128'(rd_ptr[3] - r3), 128'(1));
        push(0, w(0, 7));
        push(3, w(3, 1));
        @(negedge Clk);
        check("early.next_winner", 128'(fifo_read_en), 128'(4'b0001));
        repeat (8) @(negedge Clk);
        check("early.count", 128'(out_q.size()), 128'(3));
        if (out_q.size() == 3) begin
            check("early.src0", 128'(out_q[0].src), 128'(3));
            check("early.src1", 128'(out_q[1].src), 128'(0));
            check("early.src2", 128'(out_q[2].src), 128'(3));
        end

        // Fairness with every FIFO permanently non-empty.
        Clear_in = 1'b1;
        @(negedge Clk);
        sat_mode = 1'b1;
        out_q.delete();
        Clear_in = 1'b0;
        repeat (1000) @(negedge Clk);
        Clear_in = 1'b1;
        @(negedge Clk);
        sat_mode = 1'b0;
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        for (int i = 0; i < out_q.size(); i++) cnt[out_q[i].src]++;
        mx = cnt[0];
        mn = cnt[0];
        for (int i = 1; i < NR; i++) begin
            if (cnt[i] > mx) mx = cnt[i];
            if (cnt[i] < mn) mn = cnt[i];
        end
        check("fair.spread",   128'((mx - mn) <= MB), 128'(1));
        check("fair.progress", 128'(mn >= 150),       128'(1));

`ifdef ARB_PERF_CNT_EN
        // Saturation: preload FIFO1's counter one below the ceiling, then read three words.
        @(negedge Clk);
        Clear_in = 1'b0;
        @(negedge Clk);
        force dut.r_perf_beats = {32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0};
        #1 release dut.r_perf_beats;
        for (int i = 0; i < 3; i++) push(1, w(1, 32 + i));
        repeat (10) @(negedge Clk);
        check("perf.saturate1", 128'(perf_beats[32 +: 32]), 128'(32'hFFFF_FFFF));
        check("perf.untouched0", 128'(perf_beats[0 +: 32]), 128'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_rr_drain_arbiter.md
Name: fifo_rr_drain_arbiter

Overview:
- Shares one downstream consumer among NUM_REQ single-clock FIFO read ports. The FIFO read port has Empty_out, ReadEn_in, and a registered Data_out/Data_valid one cycle after the read.
- Drains the FIFOs round-robin in bursts of up to MAX_BURST words and muxes the returned data to one output tagged with the source index.
- Sits between the per-lane SMEM result FIFOs and the shared output/writeback stage.

Parameters:
- DATA_WIDTH, 65, width of each FIFO word.
- NUM_REQ, 4, number of FIFO read ports arbitrated (2..16).
- MAX_BURST, 4, maximum consecutive reads granted to one FIFO before rotating (>=1).
- ID_WIDTH, 2, width of the source index; must be >= clog2(NUM_REQ).

Ports:
- Clk  in  1  single clock.
- Clear_in  in  1  reset, asynchronous, active-high.
- stall  in  1  downstream back-pressure; while high, no new FIFO reads are issued.
- fifo_empty  in  NUM_REQ  Empty_out of each FIFO.
- fifo_read_en  out  NUM_REQ  ReadEn_in of each FIFO; zero or one-hot.
- fifo_data  in  NUM_REQ*DATA_WIDTH  flattened Data_out of each FIFO; slice i is [i*DATA_WIDTH +: DATA_WIDTH].
- fifo_data_valid  in  NUM_REQ  Data_valid of each FIFO.
- Data_out  out  DATA_WIDTH  registered muxed word.
- Data_valid  out  1  Data_out qualifier.
- Src_id  out  ID_WIDTH  index of the FIFO that supplied Data_out.
- Busy  out  1  high while the FSM is in BURST.

Behaviour:
- Reset (async, Clear_in=1):
  - state=IDLE, grant=0, ptr=NUM_REQ-1 (requester 0 has first priority), beat_cnt=0, pend_valid=0.
  - Data_out=0, Data_valid=0, Src_id=0, Busy=0.
  - fifo_read_en=0 immediately, combinationally on assertion.
- FSM IDLE:
  - If stall=0 and any fifo_empty bit is 0, the winner is the first non-empty index scanning ptr+1, ptr+2, … modulo NUM_REQ.
  - On a winner: grant<=winner, beat_cnt<=0, go to BURST.
  - No read is issued in IDLE. Otherwise stay in IDLE.
- FSM BURST:
  - fifo_read_en[grant] = !stall & !fifo_empty[grant]; all other bits are 0.
  - Each issued read increments beat_cnt.
  - Go to IDLE with ptr<=grant when either:
    - a read is issued with beat_cnt==MAX_BURST-1, or
    - fifo_empty[grant]=1 with no read issued this cycle.
  - stall=1 holds the state and beat_cnt; it is not counted as a beat.
- Return path:
  - A read issued in cycle N sets pend_valid<=1 and pend_id<=grant for cycle N+1.
  - In N+1: if pend_valid & fifo_data_valid[pend_id], then Data_out<=slice pend_id, Src_id<=pend_id, Data_valid<=1 in N+2; otherwise Data_valid<=0.
  - Read-to-output latency is 2 cycles.
  - fifo_data_valid from any non-pending index is ignored.
- Stall semantics:
  - stall blocks only new reads. A word already in flight still emerges, up to 1 word after stall rises.
  - The consumer must absorb that word. It is never dropped or duplicated.
- Throughput:
  - One word per cycle within a burst.
  - One bubble cycle (IDLE) between bursts.
  - MAX_BURST=1 gives pure round-robin at 50% peak.
- Boundaries:
  - All FIFOs empty: remain in IDLE with no reads.
  - Single active requester: it is re-granted after every IDLE.
  - A FIFO going empty mid-burst ends the burst early.
  - beat_cnt width is clog2(MAX_BURST+1) and never wraps.
  - Clear_in mid-burst discards the in-flight word; Data_valid is 0 at the next edge.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined:
  - Adds output port perf_beats, NUM_REQ*32 wide: per-requester 32-bit counters of issued reads, saturating at 32'hFFFFFFFF.
  - Adds output port perf_stall_cycles, 32 wide: counts cycles with stall=1 while any FIFO is non-empty, also saturating.
  - All counters reset to 0 on Clear_in.
- Undefined: both ports and all counter logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package arb_pkg holds:
  - the FSM state enum (IDLE=1'b0, BURST=1'b1);
  - a clog2 function;
  - the PERF_CNT_W=32 constant.
- Sub-module rr_pick:
  - combinational rotating priority encoder;
  - inputs: req[NUM_REQ], ptr[ID_WIDTH];
  - outputs: any, winner[ID_WIDTH].
  - Instantiated once.

Test Plan:
- Reset behaviour: Clear_in pulsed asynchronously between edges with FIFO 2 non-empty → fifo_read_en=0 at once, Data_valid=0, first grant after release goes to FIFO 2.
- Burst length: NUM_REQ=4, MAX_BURST=4; FIFO0 holds 6 words, FIFO1 holds 2 words → output Src_id sequence 0,0,0,0,1,1,0,0 with one bubble between bursts; first Data_valid arrives 3 cycles after the IDLE decision.
- Stall: stall raised in the cycle after a read of word 0xA5 → 0xA5 still appears with Data_valid=1 one cycle later; no further reads occur while stall=1; beat_cnt resumes from its held value.
- Early end: FIFO3 holding 1 word with MAX_BURST=4 → exactly one read, return to IDLE, ptr=3, next winner is 0 when 0 and 3 are both non-empty.
- Fairness: all 4 FIFOs saturated for 1000 cycles → per-source word counts within MAX_BURST of each other; fifo_read_en is never multi-hot (assertion).
- Perf counters: with ARB_PERF_CNT_EN defined, perf_beats[1] equals the number of words from FIFO1; force a counter to 32'hFFFFFFFE, then issue 3 reads → it holds at 32'hFFFFFFFF.
